// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Turns a single-cycle CPU load/store request into an APB SETUP/ACCESS
//   transfer. The latched address is decoded to one of four slave selects.
//   The selected slave's PRDATA/PREADY are muxed back to the CPU. Unmapped
//   addresses and slaves that stall too long complete with an error.
//
// Ports
//   PCLK, PRESET          bus clock, synchronous active-high reset
//   transfer/write/addr/wdata
//                         CPU request, sampled only while idle
//   rdata/ready/error     one-cycle completion (error qualifies ready)
//   PADDR/PWRITE/PWDATA   APB request, held stable for the whole transfer
//   PENABLE, PSEL0..3     APB phase and slave selects
//   PRDATA0..3, PREADY0..3
//                         per-slave read data and ready
module apb_master_bridge #(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic               mapped_q;
  logic               dec_mapped;
  logic [1:0]         dec_sel;
  logic [3:0]         psel;
  logic               pready_sel;
  logic [31:0]        prdata_sel;

  // Pages 0x10000..0x10003 of addr[31:12] map to slaves 0..3; the low two
  // page bits pick the slave once the upper 18 bits match.
  function automatic logic [2:0] decode(input logic [19:0] page);
    decode = {(page[19:2] == 18'h04000), page[1:0]};
  endfunction

  assign {dec_mapped, dec_sel} = decode(addr[31:12]);

  assign PSEL0 = psel[0];
  assign PSEL1 = psel[1];
  assign PSEL2 = psel[2];
  assign PSEL3 = psel[3];

  // Only the latched slave is listened to; other PREADY/PRDATA are ignored.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    case (sel_q)
      2'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
      2'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
      2'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
      default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
    endcase
  end

  // Request capture, state and wait counter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      sel_q    <= '0;
      mapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && transfer) begin
        PADDR    <= addr;
        PWRITE   <= write;
        PWDATA   <= wdata;
        sel_q    <= dec_sel;
        mapped_q <= dec_mapped;
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS && mapped_q && !pready_sel) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Phase outputs and completion
  always_comb begin
    state_d = state_q;
    psel    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    error   = 1'b0;
    rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (transfer) state_d = SETUP;
      end
      SETUP: begin
        if (mapped_q) psel[sel_q] = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (mapped_q) psel[sel_q] = 1'b1;
        PENABLE = 1'b1;
        if (!mapped_q) begin
          ready   = 1'b1;
          error   = 1'b1;
          state_d = IDLE;
        end else if (pready_sel) begin
          // A slave answering on the last allowed cycle still wins over the timeout.
          ready   = 1'b1;
          rdata   = PWRITE ? '0 : prdata_sel;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ready   = 1'b1;
          error   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
